// File: rtl/onehot_reg_bank_pkg.sv
// Shared constants for the one-hot written 4-entry register bank.
package onehot_reg_bank_pkg;
  localparam int ENTRIES       = 4;
  localparam int ADDR_W        = 2;
  localparam int WIDTH_DEFAULT = 32;
endpackage

// File: rtl/onehot_reg_bank_onehot_check.sv
// Combinational classifier for the write select: zero, one-hot or multi-hot, plus encoded index.
module onehot_check
  import onehot_reg_bank_pkg::*;
(
  input  logic [ENTRIES-1:0] wr_sel,
  output logic               is_zero,
  output logic               is_onehot,
  output logic               is_multi,
  output logic [ADDR_W-1:0]  idx
);

  logic [2:0] w_cnt;

  always_comb begin
    w_cnt = '0;
    idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (wr_sel[i]) begin
        w_cnt = w_cnt + 3'd1;
        idx   = i[ADDR_W-1:0];
      end
    end
    is_zero   = (w_cnt == 3'd0);
    is_onehot = (w_cnt == 3'd1);
    is_multi  = (w_cnt > 3'd1);
  end

endmodule

// File: rtl/onehot_reg_bank.sv
// 4-entry register bank with one-hot write select, two registered read ports and a sticky select-error flag.
// Optional write-to-read bypass is enabled by defining ONEHOT_REG_BANK_BYPASS_EN.
module onehot_reg_bank
  import onehot_reg_bank_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ENTRIES-1:0] wr_sel,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               clr,
  input  logic [ADDR_W-1:0]  rd_addr0,
  input  logic [ADDR_W-1:0]  rd_addr1,
  output logic [WIDTH-1:0]   rd_data0,
  output logic [WIDTH-1:0]   rd_data1,
  output logic [ENTRIES-1:0] valid,
  output logic               sel_err
);

  logic [WIDTH-1:0]   r_mem [ENTRIES];
  logic [ENTRIES-1:0] r_valid;
  logic               r_sel_err;
  logic [WIDTH-1:0]   r_rd0;
  logic [WIDTH-1:0]   r_rd1;

  logic               w_is_zero;
  logic               w_is_onehot;
  logic               w_is_multi;
  logic [ADDR_W-1:0]  w_idx;
  logic               w_wr_en;
  logic               w_err_set;
  logic [WIDTH-1:0]   w_rd0;
  logic [WIDTH-1:0]   w_rd1;

  onehot_check u_check (
    .wr_sel    (wr_sel),
    .is_zero   (w_is_zero),
    .is_onehot (w_is_onehot),
    .is_multi  (w_is_multi),
    .idx       (w_idx)
  );

  assign w_wr_en   = w_is_onehot;
  assign w_err_set = w_is_multi && !w_is_zero;

  // Unwritten entries read as zero regardless of stored contents.
  always_comb begin
    w_rd0 = r_valid[rd_addr0] ? r_mem[rd_addr0] : '0;
    w_rd1 = r_valid[rd_addr1] ? r_mem[rd_addr1] : '0;
`ifdef ONEHOT_REG_BANK_BYPASS_EN
    if (w_wr_en && (w_idx == rd_addr0)) w_rd0 = wr_data;
    if (w_wr_en && (w_idx == rd_addr1)) w_rd1 = wr_data;
`endif
  end

  // clr wins over any same-cycle write, so it also suppresses bypass data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_mem[i] <= '0;
      r_valid   <= '0;
      r_sel_err <= 1'b0;
      r_rd0     <= '0;
      r_rd1     <= '0;
    end else if (clr) begin
      for (int i = 0; i < ENTRIES; i++) r_mem[i] <= '0;
      r_valid   <= '0;
      r_sel_err <= 1'b0;
      r_rd0     <= '0;
      r_rd1     <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[w_idx]   <= wr_data;
        r_valid[w_idx] <= 1'b1;
      end
      if (w_err_set) r_sel_err <= 1'b1;
      r_rd0 <= w_rd0;
      r_rd1 <= w_rd1;
    end
  end

  assign rd_data0 = r_rd0;
  assign rd_data1 = r_rd1;
  assign valid    = r_valid;
  assign sel_err  = r_sel_err;

endmodule

// File: tb/tb_onehot_reg_bank.sv
// Scoreboard bench for onehot_reg_bank; expectations follow ONEHOT_REG_BANK_BYPASS_EN when defined.
module tb_onehot_reg_bank;

  logic        clk;
  logic        rst_n;
  logic [3:0]  wr_sel;
  logic [31:0] wr_data;
  logic        clr;
  logic [1:0]  rd_addr0;
  logic [1:0]  rd_addr1;
  logic [31:0] rd_data0;
  logic [31:0] rd_data1;
  logic [3:0]  valid;
  logic        sel_err;

  onehot_reg_bank #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .clr      (clr),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1),
    .valid    (valid),
    .sel_err  (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [3:0]  vld;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_mem [4];
  logic [3:0]  m_vld;
  logic        m_err;
  int          checks = 0;
  int          errors = 0;

`ifdef ONEHOT_REG_BANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = '0;
    m_vld = '0;
    m_err = 1'b0;
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a, input bit legal,
                                           input int idx, input logic [31:0] d);
    if (BYPASS && legal && (idx == int'(a))) return d;
    return m_vld[a] ? m_mem[a] : 32'h0;
  endfunction

  // Drive one cycle of stimulus, push the model's post-edge expectation, advance past the edge.
  task automatic cyc(input logic [3:0] sel, input logic [31:0] d, input logic c,
                     input logic [1:0] a0, input logic [1:0] a1);
    exp_t e;
    int   n;
    int   idx;
    wr_sel = sel; wr_data = d; clr = c; rd_addr0 = a0; rd_addr1 = a1;
    n   = $countones(sel);
    idx = 0;
    for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
    if (c) begin
      model_reset();
      e.rd0 = '0;
      e.rd1 = '0;
    end else begin
      e.rd0 = model_rd(a0, n == 1, idx, d);
      e.rd1 = model_rd(a1, n == 1, idx, d);
      if (n == 1) begin
        m_mem[idx] = d;
        m_vld[idx] = 1'b1;
      end else if (n > 1) begin
        m_err = 1'b1;
      end
    end
    e.vld = m_vld;
    e.err = m_err;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_sel = '0; wr_data = '0; clr = 1'b0; rd_addr0 = '0; rd_addr1 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rd_data0 !== 32'h0 || rd_data1 !== 32'h0 || valid !== 4'h0 || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rd0=%h rd1=%h valid=%b err=%b required all zero",
               rd_data0, rd_data1, valid, sel_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_write();
    exp_t e;
    cyc(4'b0001, 32'hA5A5A5A5, 1'b0, 2'd0, 2'd0);
    e = q.pop_front();
    checks++;
    if (valid !== e.vld || valid !== 4'b0001) begin
      errors++;
      $display("FAIL basic_valid: got %b required %b", valid, e.vld);
    end
    cyc(4'b0000, 32'h0, 1'b0, 2'd0, 2'd1);
    e = q.pop_front();
    checks++;
    if (rd_data0 !== e.rd0 || rd_data0 !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL basic_rd0: got %h required %h", rd_data0, e.rd0);
    end
    checks++;
    if (rd_data1 !== e.rd1) begin
      errors++;
      $display("FAIL basic_rd1_invalid: got %h required %h", rd_data1, e.rd1);
    end
  endtask

  task automatic test_zero_sel();
    exp_t e;
    cyc(4'b0000, 32'hDEADBEEF, 1'b0, 2'd0, 2'd2);
    e = q.pop_front();
    checks++;
    if (valid !== e.vld || sel_err !== e.err) begin
      errors++;
      $display("FAIL zero_sel_noop: got valid=%b err=%b required valid=%b err=%b",
               valid, sel_err, e.vld, e.err);
    end
    cyc(4'b0000, 32'h0, 1'b0, 2'd0, 2'd2);
    e = q.pop_front();
    checks++;
    if (rd_data0 !== e.rd0 || rd_data1 !== e.rd1) begin
      errors++;
      $display("FAIL zero_sel_data: got %h/%h required %h/%h", rd_data0, rd_data1, e.rd0, e.rd1);
    end
  endtask

  task automatic test_illegal_sel();
    exp_t e;
    cyc(4'b0110, 32'hFFFFFFFF, 1'b0, 2'd1, 2'd2);
    e = q.pop_front();
    checks++;
    if (sel_err !== 1'b1 || valid !== e.vld) begin
      errors++;
      $display("FAIL illegal_err: got err=%b valid=%b required err=1 valid=%b", sel_err, valid, e.vld);
    end
    checks++;
    if (rd_data0 !== e.rd0 || rd_data1 !== e.rd1) begin
      errors++;
      $display("FAIL illegal_no_bypass: got %h/%h required %h/%h", rd_data0, rd_data1, e.rd0, e.rd1);
    end
    cyc(4'b1000, 32'hCAFEF00D, 1'b0, 2'd1, 2'd2);
    e = q.pop_front();
    checks++;
    if (sel_err !== 1'b1 || valid !== e.vld || valid[3] !== 1'b1) begin
      errors++;
      $display("FAIL legal_after_err: got err=%b valid=%b required err=1 valid=%b", sel_err, valid, e.vld);
    end
    cyc(4'b0000, 32'h0, 1'b0, 2'd3, 2'd2);
    e = q.pop_front();
    checks++;
    if (rd_data0 !== 32'hCAFEF00D || rd_data1 !== e.rd1) begin
      errors++;
      $display("FAIL entry3_read: got %h/%h required cafef00d/%h", rd_data0, rd_data1, e.rd1);
    end
    cyc(4'b0000, 32'h0, 1'b1, 2'd0, 2'd0);
    e = q.pop_front();
    checks++;
    if (sel_err !== 1'b0 || valid !== 4'b0000) begin
      errors++;
      $display("FAIL clr_err: got err=%b valid=%b required err=0 valid=0000", sel_err, valid);
    end
  endtask

  task automatic test_same_cycle_rw();
    exp_t e;
    cyc(4'b0100, 32'h11, 1'b0, 2'd0, 2'd0);
    e = q.pop_front();
    cyc(4'b0100, 32'h22, 1'b0, 2'd0, 2'd2);
    e = q.pop_front();
    checks++;
    if (rd_data1 !== e.rd1 || rd_data1 !== (BYPASS ? 32'h22 : 32'h11)) begin
      errors++;
      $display("FAIL same_cycle_rd1: got %h required %h", rd_data1, e.rd1);
    end
    cyc(4'b0000, 32'h0, 1'b0, 2'd2, 2'd2);
    e = q.pop_front();
    checks++;
    if (rd_data0 !== 32'h22 || rd_data1 !== e.rd1) begin
      errors++;
      $display("FAIL after_write_rd: got %h/%h required 22/%h", rd_data0, rd_data1, e.rd1);
    end
  endtask

  task automatic test_clr_precedence();
    exp_t e;
    cyc(4'b0100, 32'h77, 1'b0, 2'd2, 2'd2);
    e = q.pop_front();
    cyc(4'b0000, 32'h0, 1'b0, 2'd2, 2'd2);
    e = q.pop_front();
    cyc(4'b0100, 32'h55, 1'b1, 2'd2, 2'd2);
    e = q.pop_front();
    checks++;
    if (valid !== 4'b0000 || rd_data0 !== 32'h0 || rd_data1 !== 32'h0 || valid !== e.vld) begin
      errors++;
      $display("FAIL clr_precedence: got valid=%b rd=%h/%h required valid=0000 rd=0/0",
               valid, rd_data0, rd_data1);
    end
    cyc(4'b0000, 32'h0, 1'b0, 2'd2, 2'd1);
    e = q.pop_front();
    checks++;
    if (rd_data0 !== 32'h0 || rd_data0 !== e.rd0) begin
      errors++;
      $display("FAIL clr_entry2: got %h required %h", rd_data0, e.rd0);
    end
  endtask

  task automatic test_dual_read();
    exp_t e;
    cyc(4'b0010, 32'h1234, 1'b0, 2'd0, 2'd0);
    e = q.pop_front();
    cyc(4'b0000, 32'h0, 1'b0, 2'd1, 2'd1);
    e = q.pop_front();
    checks++;
    if (rd_data0 !== 32'h1234 || rd_data1 !== 32'h1234 || rd_data0 !== e.rd0) begin
      errors++;
      $display("FAIL dual_read: got %h/%h required 1234/1234", rd_data0, rd_data1);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    cyc(4'b0001, 32'h10, 1'b0, 2'd0, 2'd0); e = q.pop_front();
    cyc(4'b0010, 32'h20, 1'b0, 2'd0, 2'd0); e = q.pop_front();
    cyc(4'b0100, 32'h30, 1'b0, 2'd0, 2'd0); e = q.pop_front();
    cyc(4'b1000, 32'h40, 1'b0, 2'd3, 2'd2); e = q.pop_front();
    checks++;
    if (valid !== 4'b1111 || rd_data1 !== e.rd1) begin
      errors++;
      $display("FAIL four_writes: got valid=%b rd1=%h required 1111/%h", valid, rd_data1, e.rd1);
    end
    wr_sel = 4'b0001; wr_data = 32'hDEAD0001; rd_addr0 = 2'd3; rd_addr1 = 2'd0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (rd_data0 !== 32'h0 || rd_data1 !== 32'h0 || valid !== 4'h0 || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got rd0=%h rd1=%h valid=%b err=%b required all zero",
               rd_data0, rd_data1, valid, sel_err);
    end
    @(posedge clk);
    #1;
    checks++;
    if (valid !== 4'h0) begin
      errors++;
      $display("FAIL write_in_reset: got valid=%b required 0000", valid);
    end
    #3;
    rst_n = 1'b1;
    cyc(4'b0000, 32'h0, 1'b0, 2'd3, 2'd0);
    e = q.pop_front();
    checks++;
    if (rd_data0 !== 32'h0 || rd_data0 !== e.rd0) begin
      errors++;
      $display("FAIL post_reset_rd0: got %h required 0", rd_data0);
    end
    cyc(4'b0001, 32'hBEEF, 1'b0, 2'd3, 2'd0);
    e = q.pop_front();
    checks++;
    if (valid !== 4'b0001 || valid !== e.vld) begin
      errors++;
      $display("FAIL first_write_after_reset: got %b required 0001", valid);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [3:0]  sel;
    logic        c;
    int          kind;
    for (int k = 0; k < 60; k++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6)      sel = 4'b0001 << $urandom_range(0, 3);
      else if (kind < 7) sel = 4'b0000;
      else               sel = 4'($urandom_range(0, 15)) | 4'b0011;
      c = ($urandom_range(0, 19) == 0);
      cyc(sel, $urandom, c, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      e = q.pop_front();
      checks++;
      if (rd_data0 !== e.rd0 || rd_data1 !== e.rd1 || valid !== e.vld || sel_err !== e.err) begin
        errors++;
        $display("FAIL b2b_%0d: got rd=%h/%h valid=%b err=%b required rd=%h/%h valid=%b err=%b",
                 k, rd_data0, rd_data1, valid, sel_err, e.rd0, e.rd1, e.vld, e.err);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_write();
    test_zero_sel();
    test_illegal_sel();
    test_same_cycle_rw();
    test_clr_precedence();
    test_dual_read();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_reg_bank.md
ONEHOT_REG_BANK -- requirements
Module: onehot_reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of each entry.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wr_sel  input  4  one-hot write select; bit i = decoder output i (out0..out3).
REQ-005 SHALL have port wr_data  input  WIDTH  write data.
REQ-006 SHALL have port clr  input  1  synchronous clear of all entries, valid bits and error flag.
REQ-007 SHALL have port rd_addr0  input  2  read port 0 entry index.
REQ-008 SHALL have port rd_addr1  input  2  read port 1 entry index.
REQ-009 SHALL have port rd_data0  output  WIDTH  registered read data, port 0.
REQ-010 SHALL have port rd_data1  output  WIDTH  registered read data, port 1.
REQ-011 SHALL have port valid  output  4  per-entry written-since-clear flags.
REQ-012 SHALL have port sel_err  output  1  sticky flag: illegal (multi-hot) wr_sel seen.

Function
REQ-013 Storage SHALL be 4 entries of WIDTH bits, entry i written on the rising clk edge when wr_sel == (1<<i) and clr == 0.
REQ-014 wr_sel == 0 SHALL be a no-op: no entry, valid bit or flag changes.
REQ-015 wr_sel with two or more bits set SHALL write no entry and SHALL set sel_err at that edge.
REQ-016 sel_err SHALL remain 1 until clr or reset; further legal writes SHALL proceed normally while it is set.
REQ-017 valid[i] SHALL set on the edge entry i is written; it SHALL never clear except by clr or reset.
REQ-018 Reads SHALL have 1-cycle latency: rd_dataN after edge k = contents of entry rd_addrN sampled at edge k.
REQ-019 Both read ports SHALL be independent; equal addresses SHALL return identical data.
REQ-020 Reading an entry with valid[i] == 0 SHALL return 0.
REQ-021 clr == 1 SHALL, at the edge, zero all entries, valid, sel_err and both rd_data outputs; clr SHALL take precedence over a simultaneous write, legal or illegal.
REQ-022 Same-cycle read and write of one entry SHALL behave per the Configuration section.

Reset
REQ-023 While rst_n == 0, all entries, valid, sel_err, rd_data0 and rd_data1 SHALL be 0 immediately, independent of clk.
REQ-024 Reset asserted mid-write SHALL discard the write; the first write after deassertion SHALL be accepted at the first rising edge with rst_n == 1.

Configuration
REQ-025 Macro ONEHOT_REG_BANK_BYPASS_EN SHALL select write-to-read bypass.
REQ-026 With ONEHOT_REG_BANK_BYPASS_EN defined, a read whose address equals the index of a legal same-cycle write SHALL return wr_data.
REQ-027 Without ONEHOT_REG_BANK_BYPASS_EN, that read SHALL return the entry's pre-write contents: 0 if the entry is invalid, otherwise the old value.
REQ-028 Illegal or cleared writes SHALL never be bypassed in either configuration.

Structure
REQ-029 Shared package onehot_reg_bank_pkg SHALL hold ENTRIES = 4, ADDR_W = 2 and the WIDTH default constant.
REQ-030 Sub-module onehot_check SHALL take wr_sel and produce is_zero, is_onehot, is_multi and the 2-bit encoded index; it SHALL be purely combinational.

Verification
REQ-031 Reset, then wr_sel=0001, wr_data=0xA5A5A5A5, rd_addr0=0 on the next cycle -> rd_data0=0xA5A5A5A5 one cycle later, valid=0001.
REQ-032 wr_sel=0110, wr_data=0xFFFFFFFF -> no entry changes, sel_err=1; then legal write wr_sel=1000 -> entry 3 updated, sel_err still 1; clr -> sel_err=0, valid=0000.
REQ-033 Entry 2 holds 0x11; write 0x22 to entry 2 with rd_addr1=2 in the same cycle -> rd_data1=0x22 with bypass, 0x11 without.
REQ-034 clr=1 with wr_sel=0100, wr_data=0x55 -> entry 2=0, valid=0000, rd_data0=rd_data1=0.
REQ-035 rst_n pulsed low between clock edges after 4 writes -> all outputs 0 immediately; rd_addr0=3 after release -> rd_data0=0.
REQ-036 rd_addr0=rd_addr1=1 after a write of 0x1234 to entry 1 -> both ports return 0x1234 on the same cycle.
